// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor: FSM state encoding
// and the signed-overflow rule for a - b.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Signed overflow of a - b: operands differ in sign and result sign differs from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/done handshake and results held until overwritten.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_ovf;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH:0]   w_res_cat;
    logic [WIDTH-1:0] w_res_next;
    logic             w_ovf;

    full_subtractor u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // New bit enters at the MSB; the concatenation keeps WIDTH=1 well formed.
    assign w_res_cat  = {w_d, r_res};
    assign w_res_next = w_res_cat[WIDTH:1];
    assign w_ovf      = sub_ovf(r_a_msb, r_b_msb, w_res_next[WIDTH-1]);

    // Control FSM with datapath shift and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_SHIFT;
                        r_a      <= a;
                        r_b      <= b;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_diff       <= w_res_next;
                        r_borrow_out <= w_bout;
                        r_ovf        <= w_ovf;
                    end else begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bo8;
    logic       ovf8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bo1;
    logic       ovf1;

    int n_checks;
    int n_pass;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8),
        .ovf        (ovf8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .a          (a1),
        .b          (b1),
        .busy       (busy1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (bo1),
        .ovf        (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges (including the one sampling start) until done8 shows; capped.
    task automatic wait_done8(output int lat);
        lat = 1;
        tick();
        while (!done8 && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic launch8(input logic [7:0] av, input logic [7:0] bv, output int lat);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        lat = 1;
        tick();
        start8 = 1'b0;
        while (!done8 && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy8, done8, diff8, bo8, ovf8} !== 12'h000)
            $display("FAIL reset8: got %0h expected 0", {busy8, done8, diff8, bo8, ovf8});
        else n_pass++;
        n_checks++;
        if ({busy1, done1, diff1, bo1, ovf1} !== 5'h00)
            $display("FAIL reset1: got %0h expected 0", {busy1, done1, diff1, bo1, ovf1});
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        a8 = 8'd100;
        b8 = 8'd37;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy8);
        else n_pass++;
        lat = 1;
        while (!done8 && lat < 30) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 9) $display("FAIL basic_latency: got %0d expected 9", lat);
        else n_pass++;
        n_checks++;
        if ({diff8, bo8, ovf8, busy8} !== {8'd63, 1'b0, 1'b0, 1'b0})
            $display("FAIL basic_result: got diff=%0d bo=%b ovf=%b busy=%b expected 63 0 0 0", diff8, bo8, ovf8, busy8);
        else n_pass++;
        tick();
        n_checks++;
        if ({done8, diff8} !== {1'b0, 8'd63})
            $display("FAIL basic_hold: got done=%b diff=%0d expected 0 63", done8, diff8);
        else n_pass++;
    endtask

    task automatic test_borrow_ovf();
        int lat;
        launch8(8'd5, 8'd9, lat);
        n_checks++;
        if ({lat[7:0], diff8, bo8, ovf8} !== {8'd9, 8'hFC, 1'b1, 1'b0})
            $display("FAIL neg_result: got lat=%0d diff=%0h bo=%b ovf=%b expected 9 fc 1 0", lat, diff8, bo8, ovf8);
        else n_pass++;
        tick();
        launch8(8'h80, 8'h01, lat);
        n_checks++;
        if ({lat[7:0], diff8, bo8, ovf8} !== {8'd9, 8'h7F, 1'b0, 1'b1})
            $display("FAIL ovf_neg: got lat=%0d diff=%0h bo=%b ovf=%b expected 9 7f 0 1", lat, diff8, bo8, ovf8);
        else n_pass++;
        tick();
        launch8(8'h7F, 8'hFF, lat);
        n_checks++;
        if ({lat[7:0], diff8, bo8, ovf8} !== {8'd9, 8'h80, 1'b1, 1'b1})
            $display("FAIL ovf_pos: got lat=%0d diff=%0h bo=%b ovf=%b expected 9 80 1 1", lat, diff8, bo8, ovf8);
        else n_pass++;
        tick();
        launch8(8'h5A, 8'h5A, lat);
        n_checks++;
        if ({diff8, bo8, ovf8} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL equal: got diff=%0h bo=%b ovf=%b expected 0 0 0", diff8, bo8, ovf8);
        else n_pass++;
        tick();
        launch8(8'h00, 8'h01, lat);
        n_checks++;
        if ({diff8, bo8, ovf8} !== {8'hFF, 1'b1, 1'b0})
            $display("FAIL zero_minus_one: got diff=%0h bo=%b ovf=%b expected ff 1 0", diff8, bo8, ovf8);
        else n_pass++;
        tick();
        launch8(8'hC3, 8'h00, lat);
        n_checks++;
        if ({diff8, bo8, ovf8} !== {8'hC3, 1'b0, 1'b0})
            $display("FAIL b_zero: got diff=%0h bo=%b ovf=%b expected c3 0 0", diff8, bo8, ovf8);
        else n_pass++;
        tick();
    endtask

    task automatic test_start_ignored();
        int lat;
        int extra;
        a8 = 8'd100;
        b8 = 8'd37;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'hAA;
        b8 = 8'h11;
        tick();
        start8 = 1'b1;
        a8 = 8'd1;
        b8 = 8'd2;
        tick();
        start8 = 1'b0;
        a8 = 8'h33;
        b8 = 8'hEE;
        lat = 3;
        while (!done8 && lat < 30) begin
            tick();
            lat++;
        end
        n_checks++;
        if ({lat[7:0], diff8, bo8} !== {8'd9, 8'd63, 1'b0})
            $display("FAIL ignore_start: got lat=%0d diff=%0d bo=%b expected 9 63 0", lat, diff8, bo8);
        else n_pass++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL ignore_no_second_done: got %0d extra dones expected 0", extra);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat;
        int dones;
        a8 = 8'd200;
        b8 = 8'd50;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy8, done8, diff8, bo8} !== {1'b0, 1'b0, 8'd0, 1'b0})
            $display("FAIL abort_state: got busy=%b done=%b diff=%0d bo=%b expected 0 0 0 0", busy8, done8, diff8, bo8);
        else n_pass++;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) dones++;
        end
        n_checks++;
        if (dones !== 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", dones);
        else n_pass++;
        launch8(8'd5, 8'd9, lat);
        n_checks++;
        if ({lat[7:0], diff8, bo8} !== {8'd9, 8'hFC, 1'b1})
            $display("FAIL abort_recover: got lat=%0d diff=%0h bo=%b expected 9 fc 1", lat, diff8, bo8);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        launch8(8'd100, 8'd37, lat);
        n_checks++;
        if ({lat[7:0], diff8} !== {8'd9, 8'd63})
            $display("FAIL b2b_first: got lat=%0d diff=%0d expected 9 63", lat, diff8);
        else n_pass++;
        a8 = 8'd200;
        b8 = 8'd50;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n_checks++;
        if ({busy8, diff8} !== {1'b1, 8'd63})
            $display("FAIL b2b_accept: got busy=%b diff=%0d expected 1 63", busy8, diff8);
        else n_pass++;
        lat = 1;
        while (!done8 && lat < 30) begin
            tick();
            lat++;
        end
        n_checks++;
        if ({lat[7:0], diff8, bo8, ovf8} !== {8'd9, 8'd150, 1'b0, 1'b0})
            $display("FAIL b2b_second: got lat=%0d diff=%0d bo=%b ovf=%b expected 9 150 0 0", lat, diff8, bo8, ovf8);
        else n_pass++;
        tick();
    endtask

    task automatic test_width1();
        int lat;
        a1 = 1'b0;
        b1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 30) begin
            tick();
            lat++;
        end
        n_checks++;
        if ({lat[7:0], diff1, bo1, ovf1} !== {8'd2, 1'b1, 1'b1, 1'b1})
            $display("FAIL w1_sub: got lat=%0d diff=%b bo=%b ovf=%b expected 2 1 1 1", lat, diff1, bo1, ovf1);
        else n_pass++;
        a1 = 1'b1;
        b1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 30) begin
            tick();
            lat++;
        end
        n_checks++;
        if ({lat[7:0], diff1, bo1, ovf1} !== {8'd2, 1'b1, 1'b0, 1'b0})
            $display("FAIL w1_b2b: got lat=%0d diff=%b bo=%b ovf=%b expected 2 1 0 0", lat, diff1, bo1, ovf1);
        else n_pass++;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset  = 1'b0;
        start8 = 1'b0;
        a8     = 8'd0;
        b8     = 8'd0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        test_reset();
        test_basic();
        test_borrow_ovf();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_width1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
